// File: rtl/shift_op_sequencer_pkg.sv
// Shared constants for the multi-pass shift sequencer: FSM state
// encodings, shift direction encoding and the per-pass step limit.
package shift_op_sequencer_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Largest amount the combinational shifter handles in one pass.
  localparam logic [2:0] MAX_STEP = 3'd7;

endpackage

// File: rtl/shift_op_sequencer_shifters.sv
// Combinational 8-bit logical shifter with a 3-bit shift amount.
// choice selects the direction; vacated bits are filled with zero.
module shifters
  import shift_op_sequencer_pkg::*;
(
  input  logic [7:0] a,
  input  logic [2:0] amt,
  input  logic       choice,
  output logic [7:0] y
);

  // Single logical shift in the requested direction.
  always_comb begin
    if (choice == DIR_RIGHT) y = a >> amt;
    else                     y = a << amt;
  end

endmodule

// File: rtl/shift_op_sequencer.sv
// Multi-pass shift sequencer. Accepts a command of up to 2^AMT_W-1
// positions and feeds the operand through the 3-bit shifter one pass
// per cycle (at most 7 positions each) until the amount is exhausted.
//
// state    | meaning
// ---------+---------------------------------------------------
// ST_IDLE  | waiting for a command, in_ready high
// ST_SHIFT | one shifter pass per cycle until rem_r reaches 0
// ST_DONE  | result presented, waiting for out_ready
module shift_op_sequencer
  import shift_op_sequencer_pkg::*;
#(
  parameter int AMT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic             in_dir,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             busy
);

  logic [1:0]       state_r;
  logic [7:0]       data_r;
  logic [AMT_W-1:0] rem_r;
  logic             dir_r;

  logic [2:0]       step;
  logic [AMT_W-1:0] rem_next;
  logic [7:0]       shift_y;

  // Clamp each pass to what the shifter can do and compute the remainder.
  always_comb begin
    if (rem_r > AMT_W'(MAX_STEP)) step = MAX_STEP;
    else                          step = rem_r[2:0];
    rem_next = rem_r - AMT_W'(step);
  end

  shifters u_shifters (
    .a      (data_r),
    .amt    (step),
    .choice (dir_r),
    .y      (shift_y)
  );

  // Command capture, pass iteration and output handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      data_r  <= 8'h00;
      rem_r   <= '0;
      dir_r   <= DIR_LEFT;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            data_r  <= in_data;
            rem_r   <= in_amt;
            dir_r   <= in_dir;
            state_r <= (in_amt != '0) ? ST_SHIFT : ST_DONE;
          end
        end
        ST_SHIFT: begin
          data_r <= shift_y;
          rem_r  <= rem_next;
          if (rem_next == '0) state_r <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) state_r <= ST_IDLE;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Handshake flags come from registered state only.
  always_comb begin
    in_ready  = (state_r == ST_IDLE);
    out_valid = (state_r == ST_DONE);
    busy      = (state_r != ST_IDLE);
    out_data  = data_r;
  end

endmodule

// File: tb/tb_shift_op_sequencer.sv
// Directed and randomized bench for shift_op_sequencer. Expected results
// come from a whole-amount reference shift; expected latency is
// ceil(amt/7) passes.
module tb_shift_op_sequencer;

  localparam int AMT_W = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic [AMT_W-1:0] in_amt;
  logic             in_dir;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_data;
  logic             busy;

  int n_pass  = 0;
  int n_total = 0;

  shift_op_sequencer #(.AMT_W(AMT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_dir    (in_dir),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] ref_shift(input logic [7:0] d, input int amt, input logic dir);
    if (amt >= 8) return 8'h00;
    if (dir) return d >> amt;
    return d << amt;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command with out_ready high and verify latency and result.
  task automatic run_cmd(input logic [7:0] d, input int a, input logic dir, input string tag);
    int waited;
    int k;
    logic [7:0] exp;
    exp = ref_shift(d, a, dir);
    k = (a + 6) / 7;
    check({tag, " in_ready before"}, in_ready, 1);
    in_valid  = 1'b1;
    in_data   = d;
    in_amt    = AMT_W'(a);
    in_dir    = dir;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    waited = 0;
    while (!out_valid && waited < 100) begin
      tick();
      waited++;
    end
    check({tag, " passes"}, waited, k);
    check({tag, " data"}, out_data, exp);
    tick();
    check({tag, " in_ready after handshake"}, in_ready, 1);
    check({tag, " out_valid after handshake"}, out_valid, 0);
  endtask

  initial begin
    int quiet_bad;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_amt    = '0;
    in_dir    = 1'b0;
    out_ready = 1'b0;
    #1;
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset out_data", out_data, 8'h00);
    check("reset busy", busy, 0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Zero amount, single-pass and multi-pass directed cases.
    run_cmd(8'hB5, 0, 1'b0, "zero");
    run_cmd(8'h81, 3, 1'b0, "single left3");
    run_cmd(8'h81, 7, 1'b1, "single right7");
    run_cmd(8'hFF, 31, 1'b0, "multi left31");
    run_cmd(8'hC0, 8, 1'b1, "multi right8");
    run_cmd(8'h96, 14, 1'b1, "multi right14");

    // Backpressure with a competing command held on the input.
    in_valid  = 1'b1;
    in_data   = 8'h15;
    in_amt    = AMT_W'(2);
    in_dir    = 1'b0;
    out_ready = 1'b0;
    tick();
    in_data = 8'h3C;
    in_amt  = AMT_W'(1);
    in_dir  = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp out_valid", out_valid, 1);
      check("bp out_data", out_data, 8'h54);
      check("bp in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("bp idle in_ready", in_ready, 1);
    check("bp idle out_data", out_data, 8'h54);
    tick();
    in_valid = 1'b0;
    check("bp second busy", busy, 1);
    check("bp second loaded", out_data, 8'h3C);
    tick();
    check("bp second out_valid", out_valid, 1);
    check("bp second data", out_data, 8'h1E);
    tick();
    check("bp second done", in_ready, 1);

    // Reset during the second pass of a 31-position command.
    in_valid  = 1'b1;
    in_data   = 8'h01;
    in_amt    = AMT_W'(31);
    in_dir    = 1'b0;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("pre-reset data", out_data, 8'h80);
    @(posedge clk);
    reset = 1'b1;
    #1;
    check("midreset in_ready", in_ready, 1);
    check("midreset out_valid", out_valid, 0);
    check("midreset out_data", out_data, 8'h00);
    check("midreset busy", busy, 0);
    tick();
    reset = 1'b0;
    quiet_bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid || !in_ready) quiet_bad++;
      tick();
    end
    check("post-reset quiet", quiet_bad, 0);
    run_cmd(8'h5A, 4, 1'b1, "post-reset");

    // Random back-to-back stream.
    for (int i = 0; i < 16; i++) begin
      run_cmd(8'($urandom_range(0, 255)), int'($urandom_range(0, 31)),
              1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
